mem_word_arbiter: RTL and testbench
===================================

Name: mem_word_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one 16-bit word memory: 6-bit address, 16-bit data, single write enable.
- Accepts one read or write from port A or port B at a time.
- Drives the memory interface through registered outputs and returns an ack pulse; read data is returned with the ack.
- Sits between two bus masters (e.g. CPU and DMA) and the shared word store.

Parameters:
ADDR_W, 6, address width of the memory port and of both requester ports
DATA_W, 16, data width of the memory port and of both requester ports

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
a_req  input  1  port A request; command fields held stable until a_ack
a_we  input  1  port A: 1 = write, 0 = read
a_addr  input  ADDR_W  port A word address
a_wdata  input  DATA_W  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_rdata  output  DATA_W  port A read data, valid with a_ack, held until next A read completes
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  as port A, for port B
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_data  output  DATA_W  memory write data
mem_out  input  DATA_W  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=B.
  - All outputs 0: mem_we, mem_addr, mem_data, a_ack, b_ack, a_rdata, b_rdata.
  - An in-flight access is abandoned with no ack; requesters re-issue after reset.
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- IDLE: samples a_req/b_req. If none, stays. Otherwise picks a winner, registers its command into mem_addr/mem_data/mem_we (mem_we = winner's we), records owner, goes to ACCESS.
- ACCESS (1 cycle):
  - Memory sees addr/data/we; a write commits on the closing edge.
  - Write: mem_we→0, go to DONE.
  - Read: mem_we stays 0, mem_addr held, go to CAPTURE.
- CAPTURE (reads only): mem_addr held; mem_out is registered into the owner's rdata on the closing edge; go to DONE.
- DONE: owner's ack=1 for exactly this cycle; mem_addr/mem_data hold their values; go to IDLE.
- Latency, with request sampled in IDLE at cycle 0:
  - Write: mem_we high in cycle 1, ack in cycle 2.
  - Read: ack with valid rdata in cycle 3.
  - Minimum spacing between accepted requests is 3 cycles (writes) or 4 cycles (reads).
- Arbitration (default, round-robin):
  - Only one req set: that port wins.
  - Both set: the port that is not last_grant wins.
  - last_grant updated on every grant. First grant after reset with both requesting goes to A.
- Requester rules:
  - req may drop in the ack cycle or stay high with a new command; a new command is sampled in the next IDLE.
  - Command changes while req is high and before ack are ignored; the command is latched at grant.
- Non-owner port sees ack=0 and unchanged rdata throughout.
- No starvation: with both ports requesting continuously, grants strictly alternate A,B,A,B.
- Write does not modify either rdata.
- Address is passed unmodified; the memory owns any byte-lane offsetting.

Optional Feature:
MEMARB_FIXED_PRIO_EN
- Defined: port A always wins when both request. last_grant is still tracked but ignored. B is served only when a_req=0 in IDLE; B starvation is permitted.
- Undefined: round-robin as above.
- Timing and all other behaviour are identical in both builds.

Test Plan:
- Reset then A write addr 5 data 16'hBEEF -> mem_we=1, mem_addr=5, mem_data=BEEF in cycle 1; a_ack pulse in cycle 2; b_ack stays 0.
- B read addr 5 after the previous write -> b_ack in cycle 3 with b_rdata=16'hBEEF; a_rdata unchanged (0).
- a_req and b_req both held high for 8 grants, alternating writes -> grant order A,B,A,B,A,B,A,B. With MEMARB_FIXED_PRIO_EN: A on all 8, B never acked.
- A read addr 10 (memory holds 16'h1234), a_addr changed to 11 in cycle 1 -> mem_addr stays 10 through CAPTURE; a_rdata=1234.
- rst_n asserted in CAPTURE of a B read -> all outputs 0 immediately; no b_ack; after release with b_req still high, B is re-served and acked normally.
- Single A request with req held high through ack and a new command (write addr 3 data 16'h00FF) presented in the ack cycle -> second access starts at the next IDLE sample; mem_addr=3 one cycle after that sample.

Source files
------------

// File: rtl/mem_word_arbiter.sv
// rtl/mem_word_arbiter.sv - two-requester arbiter and sequencer for one shared word memory
//
// Build option: MEMARB_FIXED_PRIO_EN
//   undefined (default) : round-robin between A and B when both request
//   defined             : A always wins a tie; B is served only when a_req=0
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata       port A command, held stable until a_ack
//   a_ack, a_rdata                  port A completion pulse, read data (held until next A read)
//   b_*                             same as port A, for port B
//   mem_we/mem_addr/mem_data        registered memory command
//   mem_out                         memory read data
module mem_word_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_d;

  // 0 = port A, 1 = port B
  logic owner_b;
  logic last_grant_b;

  logic grant_valid;
  logic grant_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and arbitration decision
  always_comb begin
    state_d     = state;
    grant_valid = 1'b0;
    grant_b     = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant_valid = 1'b1;
`ifdef MEMARB_FIXED_PRIO_EN
          grant_b     = b_req && !a_req;
`else
          // On a tie, the port that did not win last time goes next.
          grant_b     = b_req && (!a_req || !last_grant_b);
`endif
          state_d     = ACCESS;
        end
      end
      // mem_we still carries the granted command's direction during ACCESS.
      ACCESS:  state_d = mem_we ? DONE : CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: registered memory command, acks and per-port read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_b      <= 1'b0;
      last_grant_b <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      // Ack is high only in the cycle spent in DONE.
      a_ack <= (state_d == DONE) && !owner_b;
      b_ack <= (state_d == DONE) && owner_b;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_b      <= grant_b;
            last_grant_b <= grant_b;
            mem_we       <= grant_b ? b_we    : a_we;
            mem_addr     <= grant_b ? b_addr  : a_addr;
            mem_data     <= grant_b ? b_wdata : a_wdata;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
        end
        CAPTURE: begin
          if (owner_b) begin
            b_rdata <= mem_out;
          end else begin
            a_rdata <= mem_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_arbiter.sv
// tb/tb_mem_word_arbiter.sv - directed self-checking bench for mem_word_arbiter
module tb_mem_word_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:63];

  mem_word_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-write, registered-read word memory; word 10 preloaded with 16'h1234.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[10] <= 16'h1234;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
    mem_out <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_grant;
  int         k;

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {mem_we, a_ack, b_ack, mem_addr, mem_data}, 32'h0);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);
    rst_n = 1'b1;
    tick();

    // A write 5 <- BEEF
    a_req = 1; a_we = 1; a_addr = 6'd5; a_wdata = 16'hBEEF;
    tick();
    chk("aw_c1_cmd", {mem_we, 10'(mem_addr), mem_data}, {1'b1, 10'd5, 16'hBEEF});
    chk("aw_c1_ack", {a_ack, b_ack}, 2'b00);
    tick();
    chk("aw_c2_ack", {a_ack, b_ack, mem_we}, 3'b100);
    a_req = 0;
    tick();
    chk("aw_c3_ack", {a_ack, b_ack}, 2'b00);

    // B read 5
    b_req = 1; b_we = 0; b_addr = 6'd5;
    tick();
    chk("br_c1_cmd", {mem_we, 10'(mem_addr)}, {1'b0, 10'd5});
    tick();
    chk("br_c2_ack", {a_ack, b_ack}, 2'b00);
    tick();
    chk("br_c3_ack", {a_ack, b_ack}, 2'b01);
    chk("br_c3_rdata", {a_rdata, b_rdata}, {16'h0000, 16'hBEEF});
    b_req = 0;
    tick();

    // Both requesting continuously, writes, 8 grants
    a_req = 1; a_we = 1; a_addr = 6'd20; a_wdata = 16'hAAAA;
    b_req = 1; b_we = 1; b_addr = 6'd21; b_wdata = 16'hBBBB;
    for (int g = 0; g < 8; g++) begin
      k = 0;
      while (k < 6 && !(a_ack || b_ack)) begin
        tick();
        k++;
      end
`ifdef MEMARB_FIXED_PRIO_EN
      exp_grant = 2'b10;
`else
      exp_grant = (g % 2 == 0) ? 2'b10 : 2'b01;
`endif
      chk($sformatf("rr_grant%0d", g), {a_ack, b_ack}, exp_grant);
      if (g == 7) begin
        a_req = 0; b_req = 0;
      end
      tick();
    end
    tick();
    chk("rr_rdata_kept", {a_rdata, b_rdata}, {16'h0000, 16'hBEEF});

    // A read 10, address changed after grant
    a_req = 1; a_we = 0; a_addr = 6'd10;
    tick();
    chk("ar_c1_addr", {mem_we, 10'(mem_addr)}, {1'b0, 10'd10});
    a_addr = 6'd11;
    tick();
    chk("ar_c2_addr", 32'(mem_addr), 32'd10);
    tick();
    chk("ar_c3_ack", {a_ack, b_ack, 10'(mem_addr)}, {2'b10, 10'd10});
    chk("ar_c3_rdata", {a_rdata, b_rdata}, {16'h1234, 16'hBEEF});
    a_req = 0;
    tick();

    // B read 10 interrupted by reset in CAPTURE
    b_req = 1; b_we = 0; b_addr = 6'd10;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {mem_we, a_ack, b_ack, mem_addr, mem_data}, 32'h0);
    chk("rst_mid_rdata", {a_rdata, b_rdata}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_noack", {a_ack, b_ack}, 2'b00);
    rst_n = 1'b1;
    k = 0;
    while (k < 8 && !b_ack) begin
      tick();
      k++;
    end
    chk("rst_reserve_lat", k, 3);
    chk("rst_reserve_ack", {a_ack, b_ack}, 2'b01);
    chk("rst_reserve_rdata", {a_rdata, b_rdata}, {16'h0000, 16'h1234});
    b_req = 0;
    tick();

    // A request held through ack with a new command
    a_req = 1; a_we = 1; a_addr = 6'd7; a_wdata = 16'h5555;
    tick();
    tick();
    chk("hold_ack1", {a_ack, b_ack}, 2'b10);
    a_addr = 6'd3; a_wdata = 16'h00FF;
    tick();
    chk("hold_idle", {a_ack, mem_we, 10'(mem_addr)}, {2'b00, 10'd7});
    tick();
    chk("hold_cmd2", {mem_we, 10'(mem_addr), mem_data}, {1'b1, 10'd3, 16'h00FF});
    tick();
    chk("hold_ack2", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    tick();
    chk("hold_mem3", 32'(mem[3]), 32'h00FF);
    chk("hold_mem7", 32'(mem[7]), 32'h5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
